mem_dbus: RTL and testbench

- MEM pipeline stage with a multi-cycle data-memory bus master.
- Sits between the ex_mem register and the mem_wb register. Consumes the EX result, load/store opcode, effective address and store data.
- Executes loads and stores over a req/ack data bus, stalling the pipeline until the access completes.
- Formats load data into mem_wd/mem_wreg/mem_wdata for mem_wb. Non-memory instructions pass through combinationally with no stall.

---
 rtl/mem_dbus_pkg.sv | 25 ++
 rtl/mem_lane_fmt.sv | 83 ++++++++
 rtl/mem_dbus.sv | 144 ++++++++++++++
 tb/tb_mem_dbus.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dbus_pkg.sv
// Shared definitions for the MEM-stage data bus master: opcodes, bus widths, FSM states.
package mem_dbus_pkg;
   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;

   localparam logic [7:0] EXE_LB_OP  = 8'hE0;
   localparam logic [7:0] EXE_LH_OP  = 8'hE1;
   localparam logic [7:0] EXE_LW_OP  = 8'hE3;
   localparam logic [7:0] EXE_LBU_OP = 8'hE4;
   localparam logic [7:0] EXE_LHU_OP = 8'hE5;
   localparam logic [7:0] EXE_SB_OP  = 8'hE8;
   localparam logic [7:0] EXE_SH_OP  = 8'hE9;
   localparam logic [7:0] EXE_SW_OP  = 8'hEB;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } mem_state_t;
endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane mapping: store lane enables/replication, alignment check,
// and load extraction with sign or zero extension.
module mem_lane_fmt
   import mem_dbus_pkg::*;
(
   input  logic [7:0]        i_aluop,
   input  logic [1:0]        i_addr,
   input  logic [RegBus-1:0] i_reg2,
   input  logic [RegBus-1:0] i_rdata,
   output logic              o_is_mem,
   output logic              o_is_load,
   output logic              o_is_store,
   output logic              o_misalign,
   output logic [3:0]        o_sel,
   output logic [RegBus-1:0] o_wdata,
   output logic [RegBus-1:0] o_ldata
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_addr)
         2'd0:    w_byte = i_rdata[31:24];
         2'd1:    w_byte = i_rdata[23:16];
         2'd2:    w_byte = i_rdata[15:8];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr[1] ? i_rdata[15:0] : i_rdata[31:16];
   end

   always_comb begin
      o_is_mem   = 1'b0;
      o_is_load  = 1'b0;
      o_is_store = 1'b0;
      o_misalign = 1'b0;
      o_sel      = 4'b0000;
      o_wdata    = ZeroWord;
      o_ldata    = ZeroWord;
      case (i_aluop)
         EXE_LB_OP, EXE_LBU_OP: begin
            o_is_mem  = 1'b1;
            o_is_load = 1'b1;
            o_sel     = 4'b1000 >> i_addr;
            o_ldata   = (i_aluop == EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
         end
         EXE_LH_OP, EXE_LHU_OP: begin
            o_is_mem   = 1'b1;
            o_is_load  = 1'b1;
            o_misalign = i_addr[0];
            o_sel      = i_addr[1] ? 4'b0011 : 4'b1100;
            o_ldata    = (i_aluop == EXE_LH_OP) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
         end
         EXE_LW_OP: begin
            o_is_mem   = 1'b1;
            o_is_load  = 1'b1;
            o_misalign = |i_addr;
            o_sel      = 4'b1111;
            o_ldata    = i_rdata;
         end
         EXE_SB_OP: begin
            o_is_mem   = 1'b1;
            o_is_store = 1'b1;
            o_sel      = 4'b1000 >> i_addr;
            o_wdata    = {4{i_reg2[7:0]}};
         end
         EXE_SH_OP: begin
            o_is_mem   = 1'b1;
            o_is_store = 1'b1;
            o_misalign = i_addr[0];
            o_sel      = i_addr[1] ? 4'b0011 : 4'b1100;
            o_wdata    = {2{i_reg2[15:0]}};
         end
         EXE_SW_OP: begin
            o_is_mem   = 1'b1;
            o_is_store = 1'b1;
            o_misalign = |i_addr;
            o_sel      = 4'b1111;
            o_wdata    = i_reg2;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_dbus.sv
// MEM pipeline stage: runs loads/stores over a req/ack data bus, stalling the
// pipeline until the access completes, and formats the result for mem_wb.
module mem_dbus
   import mem_dbus_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RegAddrBus-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [RegBus-1:0]     ex_wdata,
   input  logic [7:0]            ex_aluop,
   input  logic [RegBus-1:0]     ex_mem_addr,
   input  logic [RegBus-1:0]     ex_reg2,
   output logic [RegAddrBus-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [RegBus-1:0]     mem_wdata,
   output logic                  stallreq,
   output logic                  d_req,
   output logic                  d_we,
   output logic [RegBus-1:0]     d_addr,
   output logic [3:0]            d_sel,
   output logic [RegBus-1:0]     d_wdata,
   input  logic                  d_ack,
   input  logic [RegBus-1:0]     d_rdata,
   output logic                  mem_err
);
   localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic [RegBus-1:0] r_rdata;

   logic              w_is_mem;
   logic              w_is_load;
   logic              w_is_store;
   logic              w_misalign;
   logic [3:0]        w_sel;
   logic [RegBus-1:0] w_wdata;
   logic [RegBus-1:0] w_ldata;
   logic              w_start;
   logic              w_timeout;

   mem_lane_fmt u_fmt (
      .i_aluop    (ex_aluop),
      .i_addr     (ex_mem_addr[1:0]),
      .i_reg2     (ex_reg2),
      .i_rdata    (d_rdata),
      .o_is_mem   (w_is_mem),
      .o_is_load  (w_is_load),
      .o_is_store (w_is_store),
      .o_misalign (w_misalign),
      .o_sel      (w_sel),
      .o_wdata    (w_wdata),
      .o_ldata    (w_ldata)
   );

   assign w_start   = (r_state == S_IDLE) && w_is_mem && !w_misalign;
   assign w_timeout = (r_state == S_ACCESS) && !d_ack && (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rdata <= ZeroWord;
         d_req   <= 1'b0;
         d_we    <= 1'b0;
         d_addr  <= ZeroWord;
         d_sel   <= 4'b0000;
         d_wdata <= ZeroWord;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  d_req   <= 1'b1;
                  d_we    <= w_is_store;
                  d_addr  <= {ex_mem_addr[RegBus-1:2], 2'b00};
                  d_sel   <= w_sel;
                  d_wdata <= w_wdata;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Ack wins over timeout when both land on the last allowed cycle.
               if (d_ack) begin
                  r_rdata <= w_ldata;
                  d_req   <= 1'b0;
                  r_state <= S_DONE;
               end else if (w_timeout) begin
                  d_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The ex_* fields stay valid throughout the stall, so DONE still reads them.
   always_comb begin
      mem_wd    = ex_wd;
      mem_wreg  = ex_wreg;
      mem_wdata = ex_wdata;
      stallreq  = 1'b0;
      mem_err   = 1'b0;
      if (rst) begin
         mem_wd    = NOPRegAddr;
         mem_wreg  = WriteDisable;
         mem_wdata = ZeroWord;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  mem_wreg = WriteDisable;
                  stallreq = !w_misalign;
                  mem_err  = w_misalign;
               end
            end
            S_ACCESS: begin
               mem_wreg = WriteDisable;
               stallreq = 1'b1;
               mem_err  = w_timeout;
            end
            S_DONE: begin
               if (w_is_load) begin
                  mem_wdata = r_rdata;
                  mem_wreg  = ex_wreg & ~r_err;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_dbus.sv
// Directed bench for mem_dbus: a transaction-level model predicts every cycle's
// outputs, and one negedge process compares them against the DUT.
module tb_mem_dbus;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [7:0]  ex_aluop;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_reg2;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_sel;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_err;

   always #5 clk = ~clk;

   mem_dbus #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .stallreq(stallreq),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .mem_err(mem_err)
   );

   typedef struct {
      string       tag;
      bit          cm;
      bit          cw;
      bit          cb;
      logic        st;
      logic [4:0]  wd;
      logic        wr;
      logic [31:0] wdat;
      logic        er;
      logic        dr;
      logic        dwe;
      logic [31:0] da;
      logic [3:0]  ds;
      logic [31:0] dw;
   } exp_t;

   exp_t q[$];
   exp_t ce;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input string tag, input bit cm, input bit cw, input bit cb,
                       input logic st, input logic [4:0] wd, input logic wr,
                       input logic [31:0] wdat, input logic er, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [3:0] ds,
                       input logic [31:0] dw);
      exp_t e;
      e.tag = tag; e.cm = cm; e.cw = cw; e.cb = cb; e.st = st; e.wd = wd; e.wr = wr;
      e.wdat = wdat; e.er = er; e.dr = dr; e.dwe = dwe; e.da = da; e.ds = ds; e.dw = dw;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         ce = q.pop_front();
         chk({ce.tag, ".stallreq"}, 32'(stallreq), 32'(ce.st));
         chk({ce.tag, ".mem_err"}, 32'(mem_err), 32'(ce.er));
         chk({ce.tag, ".d_req"}, 32'(d_req), 32'(ce.dr));
         if (ce.cm) begin
            chk({ce.tag, ".mem_wd"}, 32'(mem_wd), 32'(ce.wd));
            chk({ce.tag, ".mem_wreg"}, 32'(mem_wreg), 32'(ce.wr));
         end
         if (ce.cw) chk({ce.tag, ".mem_wdata"}, mem_wdata, ce.wdat);
         if (ce.cb) begin
            chk({ce.tag, ".d_we"}, 32'(d_we), 32'(ce.dwe));
            chk({ce.tag, ".d_addr"}, d_addr, ce.da);
            chk({ce.tag, ".d_sel"}, 32'(d_sel), 32'(ce.ds));
            if (ce.dwe) chk({ce.tag, ".d_wdata"}, d_wdata, ce.dw);
         end
      end
   end

   // Model: access size in bytes, 0 for non-memory codes.
   function automatic int m_size(input logic [7:0] op);
      case (op)
         8'hE0, 8'hE4, 8'hE8: return 1;
         8'hE1, 8'hE5, 8'hE9: return 2;
         8'hE3, 8'hEB:        return 4;
         default:             return 0;
      endcase
   endfunction

   function automatic bit m_store(input logic [7:0] op);
      return (op == 8'hE8) || (op == 8'hE9) || (op == 8'hEB);
   endfunction

   function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
      int sz = m_size(op);
      int off = int'(a[1:0]);
      logic [3:0] s = 4'b0000;
      for (int b = 0; b < 4; b++)
         if (b >= off && b < off + sz) s[3-b] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
      int sz = m_size(op);
      int off = int'(a[1:0]);
      logic [31:0] v = rd >> (8 * (4 - sz - off));
      bit sgn = (op == 8'hE0) || (op == 8'hE1);
      if (sz == 1) v = sgn ? 32'($signed(v[7:0]))  : {24'd0, v[7:0]};
      if (sz == 2) v = sgn ? 32'($signed(v[15:0])) : {16'd0, v[15:0]};
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r);
      case (m_size(op))
         1:       return {4{r[7:0]}};
         2:       return {2{r[15:0]}};
         default: return r;
      endcase
   endfunction

   // ack_wait: extra ACCESS cycles before ack (-1: never ack). stray: ack outside ACCESS.
   task automatic run_op(input string tag, input logic [7:0] op, input logic [4:0] wd,
                         input logic wr, input logic [31:0] wdat, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] rd, input int ack_wait,
                         input bit stray);
      int  sz = m_size(op);
      bit  st = m_store(op);
      bit  mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
      bit  to = (ack_wait < 0);
      int  n = to ? TIMEOUT : ack_wait + 1;
      logic [31:0] da = a & 32'hFFFF_FFFC;
      @(posedge clk); #1;
      ex_aluop = op; ex_wd = wd; ex_wreg = wr; ex_wdata = wdat;
      ex_mem_addr = a; ex_reg2 = r2; d_ack = stray; d_rdata = rd;
      if (sz == 0) begin
         push({tag, ".pass"}, 1, 1, 0, 0, wd, wr, wdat, 0, 0, 0, 0, 0, 0);
         return;
      end
      if (mis) begin
         push({tag, ".misal"}, 1, 0, 0, 0, wd, 0, 0, 1, 0, 0, 0, 0, 0);
         return;
      end
      push({tag, ".idle"}, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         d_ack = (!to && i == ack_wait);
         push({tag, ".access"}, 0, 0, 1, 1, 0, 0, 0, (to && i == n - 1), 1, st, da,
              m_sel(op, a), m_wdata(op, r2));
      end
      @(posedge clk); #1;
      d_ack = stray; d_rdata = ~rd;
      push({tag, ".done"}, 1, (!st && !to), 0, 0, wd, (st ? wr : (wr && !to)),
           m_load(op, a, rd), 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; d_ack = 1'b0; d_rdata = 32'h0;
      ex_aluop = 8'h21; ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hFFFF;
      ex_mem_addr = 32'h104; ex_reg2 = 32'h55;

      chk("pin_lb",       m_load(8'hE0, 32'h101, 32'h11F23344), 32'hFFFFFFF2);
      chk("pin_lbu",      m_load(8'hE4, 32'h101, 32'h11F23344), 32'h000000F2);
      chk("pin_lh_lo",    m_load(8'hE1, 32'h2, 32'h12348765), 32'hFFFF8765);
      chk("pin_lb_sel",   32'(m_sel(8'hE0, 32'h101)), 32'h4);
      chk("pin_sh_sel",   32'(m_sel(8'hE9, 32'h202)), 32'h3);
      chk("pin_sh_wdata", m_wdata(8'hE9, 32'hAAAABEEF), 32'hBEEFBEEF);

      @(posedge clk); #1;
      push("reset", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      rst = 1'b0;

      run_op("add",   8'h20, 5'd5, 1, 32'h1234,   32'h0,   32'h0,        32'h0,        0, 0);
      run_op("lb",    8'hE0, 5'd2, 1, 32'h101,    32'h101, 32'h0,        32'h11F23344, 0, 0);
      run_op("lbu",   8'hE4, 5'd3, 1, 32'h101,    32'h101, 32'h0,        32'h11F23344, 0, 0);
      run_op("sh",    8'hE9, 5'd0, 0, 32'h202,    32'h202, 32'hAAAABEEF, 32'h0,        3, 0);
      run_op("lw_mis",8'hE3, 5'd4, 1, 32'h6,      32'h6,   32'h0,        32'h0,        0, 0);
      run_op("lh_mis",8'hE1, 5'd4, 1, 32'h3,      32'h3,   32'h0,        32'h0,        0, 0);
      run_op("lh",    8'hE1, 5'd6, 1, 32'h2,      32'h2,   32'h0,        32'h12348765, 1, 0);
      run_op("lhu",   8'hE5, 5'd7, 1, 32'h0,      32'h0,   32'h0,        32'h12348765, 0, 0);
      run_op("lw_to", 8'hE3, 5'd8, 1, 32'h40,     32'h40,  32'h0,        32'hCAFEF00D, -1, 0);
      run_op("sb",    8'hE8, 5'd0, 0, 32'h3,      32'h3,   32'h1234565A, 32'h0,        1, 1);
      run_op("sw",    8'hEB, 5'd0, 0, 32'h10,     32'h10,  32'h87654321, 32'h0,        0, 0);
      run_op("lw",    8'hE3, 5'd9, 1, 32'h20,     32'h20,  32'h0,        32'hDEADBEEF, 2, 0);
      run_op("lb0",   8'hE0, 5'd10,1, 32'h0,      32'h0,   32'h0,        32'h80112233, 0, 1);
      run_op("or",    8'h25, 5'd11,1, 32'h5A5A,   32'h0,   32'h0,        32'h0,        0, 1);

      // Reset in the middle of an access, then a late ack that must be ignored.
      @(posedge clk); #1;
      ex_aluop = 8'hE3; ex_wd = 5'd12; ex_wreg = 1'b1; ex_wdata = 32'h40;
      ex_mem_addr = 32'h40; ex_reg2 = 32'h0; d_ack = 1'b0; d_rdata = 32'h0;
      push("rstmid.idle", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      push("rstmid.access", 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 32'h40, 4'hF, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      push("rstmid.rst", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 1'b0; d_ack = 1'b1;
      ex_aluop = 8'h20; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h55;
      push("rstmid.after", 1, 1, 1, 0, 5'd3, 1, 32'h55, 0, 0, 0, 0, 0, 0);
      run_op("post_rst_lw", 8'hE3, 5'd13, 1, 32'h80, 32'h80, 32'h0, 32'h0BADF00D, 0, 0);

      @(posedge clk); #1;
      d_ack = 1'b0;
      @(posedge clk); #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
